// File: rtl/i2_router_fifo_wr_arbiter.sv
// Round-robin write arbiter for one i2_router output FIFO: grants head flits, locks to the winner until its tail.
// Zero-latency: fifo_wr/fifo_din/sel/in_busy are combinational; locked/owner/err_proto/pkt_cnt update on the next edge.
// Backpressure: in_busy[i]=0 means port i's flit is consumed this cycle; fifo_full stalls grants and locked writes.
module i2_router_fifo_wr_arbiter #(
    parameter int                NUM_IN    = 2,
    parameter int                DATA_W    = 32,
    parameter int                TYPE_W    = 3,
    parameter logic [TYPE_W-1:0] HEAD_CODE = 3'b001,
    parameter logic [TYPE_W-1:0] TAIL_CODE = 3'b110,
    parameter logic [TYPE_W-1:0] HT_CODE   = 3'b111,
    parameter int                CNT_W     = 16,
    localparam int               SEL_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN-1:0]        in_req,
    input  logic [NUM_IN*TYPE_W-1:0] in_type,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic                     fifo_full,
    output logic                     fifo_wr,
    output logic [DATA_W-1:0]        fifo_din,
    output logic [SEL_W-1:0]         sel,
    output logic [NUM_IN-1:0]        in_busy,
    output logic                     locked,
    output logic [SEL_W-1:0]         owner,
    output logic                     err_proto,
    output logic [CNT_W-1:0]         pkt_cnt
);

    typedef enum logic [0:0] {IDLE, LOCKED} state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   rr_ptr, rr_nxt, owner_nxt;
    logic               err_nxt;
    logic               cnt_inc;
    logic [TYPE_W-1:0]  type_arr [NUM_IN];
    logic [DATA_W-1:0]  data_arr [NUM_IN];
    logic [NUM_IN-1:0]  is_start;
    logic               found;
    logic [SEL_W-1:0]   winner;

    // Port after p in cyclic order, used to move the round-robin pointer past a finished packet.
    function automatic logic [SEL_W-1:0] next_port(input logic [SEL_W-1:0] p);
        return (p == SEL_W'(NUM_IN - 1)) ? '0 : p + 1'b1;
    endfunction

    // Unpack the flat per-port buses and flag flits that may open a packet.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            type_arr[i] = in_type[i*TYPE_W +: TYPE_W];
            data_arr[i] = in_data[i*DATA_W +: DATA_W];
            is_start[i] = in_req[i] && (type_arr[i] == HEAD_CODE || type_arr[i] == HT_CODE);
        end
    end

    // First packet-start candidate at or after rr_ptr, wrapping around the port list.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] cand;
        idx    = 0;
        cand   = '0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_IN) idx = idx - NUM_IN;
            cand = SEL_W'(idx);
            if (!found && is_start[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Next-state and datapath controls; reset forces the quiet output pattern.
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        owner_nxt = owner;
        err_nxt   = 1'b0;
        cnt_inc   = 1'b0;
        fifo_wr   = 1'b0;
        sel       = '0;
        in_busy   = '1;
        if (!rst) begin
            case (state)
                IDLE: begin
                    sel = winner;
                    // Mid-packet flits with no open packet are swallowed and flagged.
                    for (int i = 0; i < NUM_IN; i++) begin
                        if (in_req[i] && !is_start[i]) begin
                            in_busy[i] = 1'b0;
                            err_nxt    = 1'b1;
                        end
                    end
                    if (!fifo_full && found) begin
                        fifo_wr         = 1'b1;
                        in_busy[winner] = 1'b0;
                        if (type_arr[winner] == HEAD_CODE) begin
                            state_nxt = LOCKED;
                            owner_nxt = winner;
                        end else begin
                            cnt_inc = 1'b1;
                            rr_nxt  = next_port(winner);
                        end
                    end
                end
                LOCKED: begin
                    sel            = owner;
                    in_busy[owner] = fifo_full;
                    if (in_req[owner] && !fifo_full) begin
                        if (is_start[owner]) begin
                            // A new head inside an open packet is dropped; the lock holds.
                            err_nxt = 1'b1;
                        end else begin
                            fifo_wr = 1'b1;
                            if (type_arr[owner] == TAIL_CODE) begin
                                state_nxt = IDLE;
                                cnt_inc   = 1'b1;
                                rr_nxt    = next_port(owner);
                            end
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign fifo_din = data_arr[sel];
    assign locked   = (state == LOCKED);

    // State, arbitration pointer, error pulse and packet counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            err_proto <= 1'b0;
            pkt_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_nxt;
            owner     <= owner_nxt;
            err_proto <= err_nxt;
            pkt_cnt   <= pkt_cnt + CNT_W'(cnt_inc);
        end
    end

endmodule
